obj_row_buffer_ctrl: RTL and testbench

Line sequencer and write-port scheduler for the OBJ row double buffer.
- Per scanline it latches the row number, sweeps the read column across the displayed half, then issues the single-cycle clear of that half.
- Sprite renderer pixel writes are accepted through a valid/ready handshake and registered onto the buffer write port.
- No write is ever presented in the same cycle as a clear.
- Sits between the OBJ renderer, the display timing generator and obj_row_double_buffer.

---
 rtl/obj_row_buffer_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_obj_row_buffer_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_row_buffer_ctrl.sv
// obj_row_buffer_ctrl: scanline sequencer and write-port scheduler for the OBJ row double buffer.
// Each line latches the row number and sweeps the read column across the displayed half.
// It then issues a single-cycle clear of that half.
// Renderer writes enter through a valid/ready handshake, are registered onto the buffer write
// port, and are never presented in the same cycle as a clear.
// Optional build macro OBJ_WRITE_FIFO_EN inserts a FIFO_DEPTH-entry write FIFO so the renderer
// is not stalled across the clear.
module obj_row_buffer_ctrl #(
    parameter int unsigned NUM_COLS   = 240,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  vcount,
    input  logic        pix_tick,
    input  logic        palettemode_in,
    input  logic        wvalid,
    output logic        wready,
    input  logic [19:0] wdata_in,
    input  logic [7:0]  wcol_in,
    input  logic        transp_in,
    output logic [7:0]  row,
    output logic [7:0]  rcol,
    output logic        pixel_valid,
    output logic        we,
    output logic [7:0]  wcol,
    output logic [19:0] wdata,
    output logic        transparent,
    output logic        palettemode,
    output logic        clear,
    output logic        line_done,
    output logic        overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAW  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);
    localparam logic [7:0] END_COL  = 8'(NUM_COLS);

    // The FIFO pointer arithmetic relies on a power-of-two depth
    if (FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("obj_row_buffer_ctrl: FIFO_DEPTH must be a nonzero power of two");
    end

    logic [1:0] state, state_nxt;
    logic [7:0] row_nxt, rcol_nxt;
    logic [7:0] pend_row, pend_row_nxt;
    logic       pending, pending_nxt;
    logic       overrun_nxt;
    logic       line_done_nxt;
    logic       clear_next;
    logic       wr_open;

    // Next-state and sequencer decode
    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        rcol_nxt      = rcol;
        pend_row_nxt  = pend_row;
        pending_nxt   = pending;
        overrun_nxt   = overrun;
        line_done_nxt = 1'b0;
        clear_next    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (line_start) begin
                    state_nxt = ST_DRAW;
                    row_nxt   = vcount;
                    rcol_nxt  = 8'd0;
                end
            end
            ST_DRAW: begin
                if (line_start) begin
                    // New line before the sweep finished: abort, clear, then restart
                    overrun_nxt  = 1'b1;
                    pending_nxt  = 1'b1;
                    pend_row_nxt = vcount;
                    rcol_nxt     = END_COL;
                    state_nxt    = ST_CLEAR;
                    clear_next   = 1'b1;
                end else if (pix_tick) begin
                    if (rcol == LAST_COL) begin
                        rcol_nxt   = END_COL;
                        state_nxt  = ST_CLEAR;
                        clear_next = 1'b1;
                    end else begin
                        rcol_nxt = rcol + 8'd1;
                    end
                end
            end
            ST_CLEAR: begin
                if (line_start || pending) begin
                    // A line_start arriving in this very cycle counts as pending
                    state_nxt   = ST_DRAW;
                    row_nxt     = line_start ? vcount : pend_row;
                    rcol_nxt    = 8'd0;
                    pending_nxt = 1'b0;
                    if (line_start) begin
                        overrun_nxt = 1'b1;
                    end
                end else begin
                    state_nxt     = ST_DONE;
                    line_done_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            row       <= 8'd0;
            rcol      <= END_COL;
            pend_row  <= 8'd0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            clear     <= 1'b0;
            line_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            rcol      <= rcol_nxt;
            pend_row  <= pend_row_nxt;
            pending   <= pending_nxt;
            overrun   <= overrun_nxt;
            clear     <= clear_next;
            line_done <= line_done_nxt;
        end
    end

    // Read side qualifies the buffer output with the pixel tick while drawing
    assign pixel_valid = (state == ST_DRAW) && pix_tick;

    // The write register may only load when no clear is or will be on the port
    assign wr_open = !clear_next && (state != ST_CLEAR);

    logic        src_valid;
    logic [7:0]  src_col;
    logic [19:0] src_data;
    logic        src_transp;

`ifdef OBJ_WRITE_FIFO_EN
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [28:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = wvalid && !fifo_full;
    assign pop        = !fifo_empty && wr_open;
    assign wready     = !fifo_full;

    assign src_valid  = pop;
    assign src_col    = fifo_mem[rd_ptr][28:21];
    assign src_data   = fifo_mem[rd_ptr][20:1];
    assign src_transp = fifo_mem[rd_ptr][0];

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wcol_in, wdata_in, transp_in};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end
`else
    assign wready     = wr_open;
    assign src_valid  = wvalid && wr_open;
    assign src_col    = wcol_in;
    assign src_data   = wdata_in;
    assign src_transp = transp_in;
`endif

    // Buffer write port register; off-screen columns are consumed without a write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we          <= 1'b0;
            wcol        <= 8'd0;
            wdata       <= 20'd0;
            transparent <= 1'b0;
            palettemode <= 1'b0;
        end else begin
            we          <= src_valid && (src_col < END_COL);
            palettemode <= palettemode_in;
            if (src_valid) begin
                wcol        <= src_col;
                wdata       <= src_data;
                transparent <= src_transp;
            end
        end
    end

endmodule

// File: tb/tb_obj_row_buffer_ctrl.sv
// tb_obj_row_buffer_ctrl: directed stimulus with a queue-based scoreboard for obj_row_buffer_ctrl.
module tb_obj_row_buffer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        line_start = 1'b0;
    logic [7:0]  vcount = 8'd0;
    logic        pix_tick = 1'b0;
    logic        palettemode_in = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [19:0] wdata_in = 20'd0;
    logic [7:0]  wcol_in = 8'd0;
    logic        transp_in = 1'b0;
    logic [7:0]  row, rcol, wcol;
    logic        pixel_valid, we, transparent, palettemode, clear, line_done, overrun;
    logic [19:0] wdata;

    obj_row_buffer_ctrl dut (
        .clock(clock), .reset(reset), .line_start(line_start), .vcount(vcount),
        .pix_tick(pix_tick), .palettemode_in(palettemode_in), .wvalid(wvalid),
        .wready(wready), .wdata_in(wdata_in), .wcol_in(wcol_in), .transp_in(transp_in),
        .row(row), .rcol(rcol), .pixel_valid(pixel_valid), .we(we), .wcol(wcol),
        .wdata(wdata), .transparent(transparent), .palettemode(palettemode),
        .clear(clear), .line_done(line_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  col;
        logic [19:0] data;
        logic        tr;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pix_col_q[$];
    logic [7:0]  pix_row_q[$];
    wr_t         wr_q[$];
    int          ev_q[$];     // 1 = clear, 2 = line_done

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic start_line(input logic [7:0] vc);
        line_start = 1'b1;
        vcount     = vc;
        cyc();
        line_start = 1'b0;
        chk("start_row", row, vc);
        chk("start_rcol", rcol, 0);
    endtask

    task automatic ticks(input int n, input logic [7:0] r);
        for (int i = 0; i < n; i++) begin
            pix_col_q.push_back(8'(i));
            pix_row_q.push_back(r);
            pix_tick = 1'b1;
            cyc();
        end
        pix_tick = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (pixel_valid) begin
                if (pix_col_q.size() == 0) begin
                    chk("pix_unexpected", pixel_valid, 0);
                end else begin
                    chk("pix_rcol", rcol, pix_col_q.pop_front());
                    chk("pix_row", row, pix_row_q.pop_front());
                end
            end
            if (we) begin
                if (wr_q.size() == 0) begin
                    chk("we_unexpected", we, 0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_col", wcol, e.col);
                    chk("wr_data", wdata, e.data);
                    chk("wr_transp", transparent, e.tr);
                end
            end
            if (clear) begin
                chk("we_clear_excl", we, 0);
                if (ev_q.size() == 0) chk("clear_unexpected", clear, 0);
                else chk("ev_clear", 1, ev_q.pop_front());
            end
            if (line_done) begin
                if (ev_q.size() == 0) chk("done_unexpected", line_done, 0);
                else chk("ev_line_done", 2, ev_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  exp_wr;
        wr_t e;

        reset = 1'b1;
        cyc();
        chk("rst_rcol", rcol, 240);
        chk("rst_row", row, 0);
        chk("rst_we", we, 0);
        chk("rst_clear", clear, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_wdata", wdata, 0);
        reset = 1'b0;
        cyc();

        // Full line, row 37
        ev_q.push_back(1);
        ev_q.push_back(2);
        start_line(8'd37);
        ticks(240, 8'd37);
        chk("l1_clear", clear, 1);
        chk("l1_rcol_end", rcol, 240);
        cyc();
        chk("l1_done", line_done, 1);
        chk("l1_clear_off", clear, 0);
        cyc();
        chk("l1_done_pulse", line_done, 0);
        chk("l1_row", row, 37);

        // Full line, row 50, with continuous writes to columns 5..250
        ev_q.push_back(1);
        ev_q.push_back(2);
        c = 5;
        for (int k = 0; k < 260; k++) begin
            line_start = (k == 0);
            vcount     = 8'd50;
            pix_tick   = (k >= 1 && k <= 240);
            if (pix_tick) begin
                pix_col_q.push_back(8'(k - 1));
                pix_row_q.push_back(8'd50);
            end
            wvalid    = (c <= 250);
            wcol_in   = 8'(c);
            wdata_in  = {12'h5A0, 8'(c)};
            transp_in = c[0];
`ifdef OBJ_WRITE_FIFO_EN
            exp_wr = 1'b1;
`else
            exp_wr = !(k == 240 || k == 241);
`endif
            #1;
            if (wvalid) chk("wready", wready, exp_wr);
            if (wvalid && exp_wr) begin
                if (c < 240) begin
                    e.col  = 8'(c);
                    e.data = {12'h5A0, 8'(c)};
                    e.tr   = c[0];
                    wr_q.push_back(e);
                end
                c++;
            end
            cyc();
        end
        line_start = 1'b0;
        pix_tick   = 1'b0;
        wvalid     = 1'b0;
        chk("l2_row", row, 50);
        chk("l2_overrun", overrun, 0);

        // line_start mid-sweep aborts, clears, then redraws row 8
        start_line(8'd20);
        ticks(120, 8'd20);
        ev_q.push_back(1);
        line_start = 1'b1;
        vcount     = 8'd8;
        cyc();
        line_start = 1'b0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_clear", clear, 1);
        chk("ovr_rcol", rcol, 240);
        chk("ovr_row_hold", row, 20);
        cyc();
        chk("ovr_row", row, 8);
        chk("ovr_rcol0", rcol, 0);
        chk("ovr_no_done", line_done, 0);

        // line_start during the clear cycle restarts on exit
        ticks(240, 8'd8);
        chk("cl_clear", clear, 1);
        ev_q.push_back(1);
        line_start = 1'b1;
        vcount     = 8'd99;
        cyc();
        line_start = 1'b0;
        chk("cl_row", row, 99);
        chk("cl_rcol0", rcol, 0);
        chk("cl_no_done", line_done, 0);
        chk("cl_overrun", overrun, 1);
        ev_q.push_back(1);
        ev_q.push_back(2);
        ticks(240, 8'd99);
        cyc();
        cyc();
        chk("cl_overrun_sticky", overrun, 1);
        chk("cl_rcol_end", rcol, 240);

        // Reset mid-DRAW at rcol 100 with a write on the port
        start_line(8'd5);
        ticks(100, 8'd5);
        chk("mid_rcol", rcol, 100);
        wvalid  = 1'b1;
        wcol_in = 8'd7;
        cyc();
        wvalid = 1'b0;
        chk("mid_we", we, 1);
        reset = 1'b1;
        #1;
        chk("ar_rcol", rcol, 240);
        chk("ar_row", row, 0);
        chk("ar_we", we, 0);
        chk("ar_clear", clear, 0);
        chk("ar_overrun", overrun, 0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        chk("ar_no_clear", clear, 0);
        chk("ar_idle_rcol", rcol, 240);
        chk("ar_wready", wready, 1);

        chk("pix_q_drained", pix_col_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("ev_q_drained", ev_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
